// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU decode/issue slice: ALU commands, RV32I opcodes and the
// decoded operation record held in the issue pipeline register (and skid entry).
package alu_issue_pkg;

    typedef enum logic [3:0] {
        ADD, SUB, SLL, LT, LTU, XOR, SRL, SRA, OR, AND, EQ, NE, GE, GEU
    } command_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        command_t    command;
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [4:0]  rd;
        logic        is_branch;
        logic [31:0] branch_target;
        logic        illegal;
    } issue_t;

    localparam issue_t ISSUE_RESET = '{command: ADD, lhs: 32'd0, rhs: 32'd0, rd: 5'd0,
                                       is_branch: 1'b0, branch_target: 32'd0, illegal: 1'b0};

    // Shared OP/OP-IMM funct3 map; alt selects SUB/SRA
    function automatic command_t op_command(input logic [2:0] funct3, input logic alt);
        command_t cmd;
        cmd = ADD;
        case (funct3)
            3'b000: cmd = alt ? SUB : ADD;
            3'b001: cmd = SLL;
            3'b010: cmd = LT;
            3'b011: cmd = LTU;
            3'b100: cmd = XOR;
            3'b101: cmd = alt ? SRA : SRL;
            3'b110: cmd = OR;
            3'b111: cmd = AND;
            default: cmd = ADD;
        endcase
        return cmd;
    endfunction

endpackage

// File: rtl/issue_decode.sv
// Purely combinational RV32I decode of one instruction plus its register operands and pc
// into an issue_t record; every illegal encoding collapses to an all-zero ADD.
module issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output issue_t      op
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] u_imm;
    logic [31:0] b_imm;
    logic        is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign i_imm    = {{20{instr[31]}}, instr[31:20]};
    assign u_imm    = {instr[31:12], 12'b0};
    assign b_imm    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        issue_t d;
        logic   bad;
        d   = ISSUE_RESET;
        bad = 1'b0;
        case (opcode)
            OPC_OP: begin
                d.command = op_command(funct3, funct7 == 7'h20);
                d.lhs     = rs1_data;
                d.rhs     = rs2_data;
                d.rd      = instr[11:7];
                bad = !((funct7 == 7'h00) ||
                        ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_OP_IMM: begin
                d.lhs = rs1_data;
                d.rd  = instr[11:7];
                if (is_shift) begin
                    d.command = op_command(funct3, funct7 == 7'h20);
                    d.rhs     = {27'd0, instr[24:20]};
                    bad = !((funct7 == 7'h00) || ((funct7 == 7'h20) && (funct3 == 3'b101)));
                end else begin
                    d.command = op_command(funct3, 1'b0);
                    d.rhs     = i_imm;
                end
            end
            OPC_BRANCH: begin
                d.lhs           = rs1_data;
                d.rhs           = rs2_data;
                d.is_branch     = 1'b1;
                d.branch_target = pc + b_imm;
                case (funct3)
                    3'b000:  d.command = EQ;
                    3'b001:  d.command = NE;
                    3'b100:  d.command = LT;
                    3'b101:  d.command = GE;
                    3'b110:  d.command = LTU;
                    3'b111:  d.command = GEU;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LUI: begin
                d.rhs = u_imm;
                d.rd  = instr[11:7];
            end
            OPC_AUIPC: begin
                d.lhs = pc;
                d.rhs = u_imm;
                d.rd  = instr[11:7];
            end
            default: bad = 1'b1;
        endcase
        op = d;
        if (bad) begin
            op         = ISSUE_RESET;
            op.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage feeding the ALU: valid/ready handshake, 1-cycle output register and,
// when ALU_ISSUE_SKID_EN is defined, a one-entry skid buffer that registers in_ready.
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output command_t    out_command,
    output logic [31:0] out_lhs,
    output logic [31:0] out_rhs,
    output logic [4:0]  out_rd,
    output logic        out_is_branch,
    output logic [31:0] out_branch_target,
    output logic        out_illegal
);

    issue_t decoded;
    issue_t out_reg;
    logic   out_valid_q;
    logic   in_fire;

    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign in_fire  = in_valid && in_ready;

    issue_decode u_decode (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .op       (decoded)
    );

`ifdef ALU_ISSUE_SKID_EN
    issue_t skid_reg;
    logic   skid_full;
    logic   out_free;

    assign in_ready = !flush && !skid_full;
    assign out_free = !out_valid_q || out_ready;

    // Skid entry always drains into the output first, so in-order issue is preserved
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_reg     <= ISSUE_RESET;
            skid_full   <= 1'b0;
            skid_reg    <= ISSUE_RESET;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_full   <= 1'b0;
        end else if (out_free) begin
            if (skid_full) begin
                out_reg     <= skid_reg;
                out_valid_q <= 1'b1;
                skid_full   <= 1'b0;
            end else if (in_fire) begin
                out_reg     <= decoded;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_reg  <= decoded;
            skid_full <= 1'b1;
        end
    end
`else
    assign in_ready = !flush && (!out_valid_q || out_ready);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_reg     <= ISSUE_RESET;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (in_fire) begin
            out_reg     <= decoded;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
`endif

    assign out_valid         = out_valid_q;
    assign out_command       = out_reg.command;
    assign out_lhs           = out_reg.lhs;
    assign out_rhs           = out_reg.rhs;
    assign out_rd            = out_reg.rd;
    assign out_is_branch     = out_reg.is_branch;
    assign out_branch_target = out_reg.branch_target;
    assign out_illegal       = out_reg.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: queue-based reference model checked every cycle,
// plus directed vectors with literal expectations. Honours ALU_ISSUE_SKID_EN.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    command_t    out_command;
    logic [31:0] out_lhs, out_rhs, out_branch_target;
    logic [4:0]  out_rd;
    logic        out_is_branch, out_illegal;

    int tests = 0;
    int failures = 0;
    issue_t expQ[$];

`ifdef ALU_ISSUE_SKID_EN
    localparam int CAPACITY = 2;
`else
    localparam int CAPACITY = 1;
`endif

    alu_issue dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_command(out_command), .out_lhs(out_lhs), .out_rhs(out_rhs),
        .out_rd(out_rd), .out_is_branch(out_is_branch), .out_branch_target(out_branch_target),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Reference decode written from the instruction-set rules
    function automatic issue_t modelDecode(logic [31:0] instr, logic [31:0] pc,
                                           logic [31:0] a, logic [31:0] b);
        issue_t r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic bad;
        int offset;
        command_t arith[8];
        command_t bra[8];
        arith = '{ADD, SLL, LT, LTU, XOR, SRL, OR, AND};
        bra = '{EQ, NE, ADD, ADD, LT, GE, LTU, GEU};
        opc = instr[6:0];
        f3 = instr[14:12];
        f7 = instr[31:25];
        bad = 1'b0;
        r = '{command: ADD, lhs: 0, rhs: 0, rd: 0, is_branch: 0, branch_target: 0, illegal: 0};
        offset = int'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        if (opc == 7'h33) begin
            r.command = arith[f3];
            if (f7 == 7'h20 && f3 == 3'd0) r.command = SUB;
            if (f7 == 7'h20 && f3 == 3'd5) r.command = SRA;
            r.lhs = a; r.rhs = b; r.rd = instr[11:7];
            bad = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        end else if (opc == 7'h13) begin
            r.command = arith[f3];
            r.lhs = a; r.rd = instr[11:7];
            if (f3 == 3'd1 || f3 == 3'd5) begin
                r.rhs = 32'(instr[24:20]);
                if (f3 == 3'd5 && f7 == 7'h20) r.command = SRA;
                bad = !(f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
            end else begin
                r.rhs = 32'(int'($signed(instr[31:20])));
            end
        end else if (opc == 7'h63) begin
            r.command = bra[f3];
            r.lhs = a; r.rhs = b; r.is_branch = 1'b1;
            r.branch_target = pc + 32'(offset);
            bad = (f3 == 3'd2 || f3 == 3'd3);
        end else if (opc == 7'h37) begin
            r.rhs = instr & 32'hFFFFF000; r.rd = instr[11:7];
        end else if (opc == 7'h17) begin
            r.lhs = pc; r.rhs = instr & 32'hFFFFF000; r.rd = instr[11:7];
        end else begin
            bad = 1'b1;
        end
        if (bad)
            r = '{command: ADD, lhs: 0, rhs: 0, rd: 0, is_branch: 0, branch_target: 0, illegal: 1};
        return r;
    endfunction

    function automatic logic modelReady();
        if (flush) return 1'b0;
        if (CAPACITY == 2) return expQ.size() < 2;
        return (expQ.size() == 0) || out_ready;
    endfunction

    // Model advances on the same edges as the DUT, from the inputs held across the edge
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            expQ.delete();
        end else begin
            logic rdy;
            rdy = modelReady();
            if (flush) begin
                expQ.delete();
            end else begin
                if (expQ.size() > 0 && out_ready) void'(expQ.pop_front());
                if (in_valid && rdy) expQ.push_back(modelDecode(in_instr, in_pc, rs1_data, rs2_data));
            end
        end
    end

    // Every cycle, after the next inputs settle, compare DUT against the model
    always @(negedge clk) begin
        issue_t got;
        #2;
        got = '{out_command, out_lhs, out_rhs, out_rd, out_is_branch, out_branch_target, out_illegal};
        tests++;
        if (out_valid !== (expQ.size() != 0)) begin
            failures++;
            $display("[TB] FAIL model_valid: got %0b expected %0b", out_valid, expQ.size() != 0);
        end
        if (expQ.size() != 0) begin
            tests++;
            if (got !== expQ[0]) begin
                failures++;
                $display("[TB] FAIL model_fields: got %h expected %h", got, expQ[0]);
            end
        end
        tests++;
        if (in_ready !== modelReady()) begin
            failures++;
            $display("[TB] FAIL model_in_ready: got %0b expected %0b", in_ready, modelReady());
        end
        tests++;
        if (rs1_addr !== in_instr[19:15] || rs2_addr !== in_instr[24:20]) begin
            failures++;
            $display("[TB] FAIL rs_addr: got %0d/%0d expected %0d/%0d", rs1_addr, rs2_addr,
                     in_instr[19:15], in_instr[24:20]);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] instr, input logic [31:0] pc,
                                 input logic [31:0] a, input logic [31:0] b);
        bit accepted;
        accepted = 1'b0;
        in_valid = 1'b1; in_instr = instr; in_pc = pc; rs1_data = a; rs2_data = b;
        for (int i = 0; i < 20 && !accepted; i++) begin
            #1;
            accepted = in_ready;
            step();
        end
        in_valid = 1'b0;
        if (!accepted) begin
            tests++;
            failures++;
            $display("[TB] FAIL accept_timeout: instr %h not accepted within 20 cycles", instr);
        end
    endtask

    task automatic checkOutput(input string name, input logic expValid, input command_t c,
                               input logic [31:0] l, input logic [31:0] r, input logic [4:0] rd,
                               input logic br, input logic [31:0] tgt, input logic ill);
        tests++;
        if (out_valid !== expValid || out_command !== c || out_lhs !== l || out_rhs !== r ||
            out_rd !== rd || out_is_branch !== br || out_illegal !== ill ||
            (br && out_branch_target !== tgt)) begin
            failures++;
            $display("[TB] FAIL %s: got v=%0b cmd=%0d lhs=%h rhs=%h rd=%0d br=%0b tgt=%h ill=%0b, expected v=%0b cmd=%0d lhs=%h rhs=%h rd=%0d br=%0b tgt=%h ill=%0b",
                     name, out_valid, out_command, out_lhs, out_rhs, out_rd, out_is_branch,
                     out_branch_target, out_illegal, expValid, c, l, r, rd, br, tgt, ill);
        end
    endtask

    task automatic checkBit(input string name, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    logic [31:0] vecInstr[9] = '{32'h007302B3, 32'hABCDE3B7, 32'hFFF00093, 32'h0000007F,
                                 32'h02208033, 32'h40109093, 32'h4020C0B3, 32'hFE20FEE3,
                                 32'h0FF0B113};

    initial begin
        repeat (2) step();
        checkOutput("reset_state", 1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
        checkBit("reset_target_zero", out_branch_target == 32'd0, 1'b1);
        reset_n = 1'b1;
        step();
        out_ready = 1'b1;

        applyStimulus(32'h40208033, 32'h0, 32'd10, 32'd3);
        checkOutput("sub", 1'b1, SUB, 32'd10, 32'd3, 5'd0, 1'b0, 32'd0, 1'b0);
        applyStimulus(32'h4050D093, 32'h4, 32'h80000000, 32'd0);
        checkOutput("srai", 1'b1, SRA, 32'h80000000, 32'd5, 5'd1, 1'b0, 32'd0, 1'b0);
        applyStimulus(32'h12345197, 32'h1000, 32'd0, 32'd0);
        checkOutput("auipc", 1'b1, ADD, 32'h1000, 32'h12345000, 5'd3, 1'b0, 32'd0, 1'b0);
        applyStimulus(32'h00209463, 32'hFFFFFFFC, 32'd7, 32'd9);
        checkOutput("bne_wrap", 1'b1, NE, 32'd7, 32'd9, 5'd0, 1'b1, 32'h00000004, 1'b0);
        applyStimulus(32'h0020A463, 32'h200, 32'd7, 32'd9);
        checkOutput("branch_f3_010", 1'b1, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b1);

        for (int i = 0; i < 9; i++)
            applyStimulus(vecInstr[i], 32'h100 + 32'(i * 4), 32'h1111 * 32'(i + 1), 32'hF0F0F0F0);
        step();
        checkBit("drained_empty", out_valid, 1'b0);

        // Three back-to-back words against a two-cycle stall
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(32'h007302B3, 32'h300, 32'd1, 32'd2);
                applyStimulus(32'h40208033, 32'h304, 32'd3, 32'd4);
                applyStimulus(32'h0020C463, 32'h308, 32'd5, 32'd6);
            end
            begin
                step();
                checkBit("stall_in_ready", in_ready, CAPACITY == 2);
                step();
                out_ready = 1'b1;
            end
        join
        repeat (3) step();

        // Flush with storage full and a word offered
        out_ready = 1'b0;
        applyStimulus(32'h007302B3, 32'h400, 32'd11, 32'd12);
        if (CAPACITY == 2) applyStimulus(32'h40208033, 32'h404, 32'd13, 32'd14);
        in_valid = 1'b1; in_instr = 32'h12345197; in_pc = 32'h408; flush = 1'b1;
        #1;
        checkBit("flush_in_ready", in_ready, 1'b0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        checkBit("flush_out_valid", out_valid, 1'b0);
        step();
        checkBit("flush_no_accept", out_valid, 1'b0);

        // Reset while an operation is held drops it
        applyStimulus(32'hABCDE3B7, 32'h500, 32'd0, 32'd0);
        checkBit("held_before_reset", out_valid, 1'b1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        out_ready = 1'b1;
        step();
        checkOutput("after_reset", 1'b0, ADD, 32'd0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
